// File: rtl/tri_state_bus_arbiter_pkg.sv
// Shared definitions for the tri-state bus arbiter.
//   arb_state_t      : FSM state encodings (IDLE/GRANT/TURN)
//   DEF_TURN_CYCLES  : default bus-idle gap between owners
//   DEF_MAX_HOLD     : default grant-cycle limit for the timeout build
//   id_width()       : width of an owner index for N requesters
package tri_state_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_t;

  localparam int DEF_TURN_CYCLES = 1;
  localparam int DEF_MAX_HOLD    = 8;

  // Never narrower than one bit, so N_REQ=2 still gets a usable index.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tri_state_bus_arbiter_rr_pick.sv
// Round-robin winner selection, purely combinational.
//   req     : request vector
//   ptr     : index of the previous owner (lowest priority)
//   winner  : first set request found searching upward from ptr+1, wrapping
//   any_req : at least one request is set
module tri_state_bus_arbiter_rr_pick
  import tri_state_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]           req,
  input  logic [id_width(N_REQ)-1:0] ptr,
  output logic [id_width(N_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int IDW = id_width(N_REQ);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_state_bus_arbiter.sv
// Tri-state bus arbiter: hands one shared bus to N_REQ tri-state drivers in
// round-robin order through active-low chip selects, with an all-released
// turnaround gap of TURN_CYCLES cycles between owners.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   req      : per-driver level request
//   nCS      : per-driver chip select, active low, registered, at most one low
//   grant_id : current owner index, meaningful while bus_busy is high
//   bus_busy : high while any nCS is low
// Optional build macro TRI_STATE_ARB_TIMEOUT_EN: limits each ownership to
// MAX_HOLD grant cycles, after which the bus is released even if req persists.
module tri_state_bus_arbiter
  import tri_state_bus_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           nCS,
  output logic [id_width(N_REQ)-1:0] grant_id,
  output logic                       bus_busy
);

  localparam int IDW = id_width(N_REQ);

  arb_state_t     state, state_n;
  logic [IDW-1:0] ptr, ptr_n, gid_n, winner;
  logic [N_REQ-1:0] ncs_n;
  logic           busy_n, any_req, do_arb, rel;
  logic [31:0]    turn_cnt, turn_n;
`ifdef TRI_STATE_ARB_TIMEOUT_EN
  logic [31:0]    hold_cnt, hold_n;
`endif

  tri_state_bus_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      nCS      <= '1;
      grant_id <= '0;
      bus_busy <= 1'b0;
      ptr      <= IDW'(N_REQ - 1);
      turn_cnt <= '0;
`ifdef TRI_STATE_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      nCS      <= ncs_n;
      grant_id <= gid_n;
      bus_busy <= busy_n;
      ptr      <= ptr_n;
      turn_cnt <= turn_n;
`ifdef TRI_STATE_ARB_TIMEOUT_EN
      hold_cnt <= hold_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    ncs_n   = nCS;
    gid_n   = grant_id;
    busy_n  = bus_busy;
    ptr_n   = ptr;
    turn_n  = turn_cnt;
    do_arb  = 1'b0;
    rel     = 1'b0;
`ifdef TRI_STATE_ARB_TIMEOUT_EN
    hold_n  = hold_cnt;
`endif

    case (state)
      IDLE: begin
        ncs_n  = '1;
        busy_n = 1'b0;
        do_arb = 1'b1;
      end
      GRANT: begin
        rel = !req[grant_id];
`ifdef TRI_STATE_ARB_TIMEOUT_EN
        hold_n = hold_cnt + 32'd1;
        if (hold_cnt == 32'(MAX_HOLD - 1)) rel = 1'b1;
`endif
        if (rel) begin
          state_n = TURN;
          ncs_n   = '1;
          busy_n  = 1'b0;
          turn_n  = '0;
        end
      end
      TURN: begin
        // Requests only matter at the final turnaround edge.
        if (turn_cnt == 32'(TURN_CYCLES - 1)) begin
          state_n = IDLE;
          do_arb  = 1'b1;
        end else begin
          turn_n = turn_cnt + 32'd1;
        end
      end
      default: begin
        state_n = IDLE;
        ncs_n   = '1;
        busy_n  = 1'b0;
      end
    endcase

    if (do_arb && any_req) begin
      state_n       = GRANT;
      ncs_n         = '1;
      ncs_n[winner] = 1'b0;
      gid_n         = winner;
      ptr_n         = winner;
      busy_n        = 1'b1;
`ifdef TRI_STATE_ARB_TIMEOUT_EN
      hold_n        = '0;
`endif
    end
  end

endmodule

// File: tb/tb_tri_state_bus_arbiter.sv
// Bench for tri_state_bus_arbiter: two instances (turnaround of 1 and 3
// cycles) driven by directed and random request traffic and compared each
// cycle against a bus-ownership model. Honours TRI_STATE_ARB_TIMEOUT_EN.
module tb_tri_state_bus_arbiter;

`ifdef TRI_STATE_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif
  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] ncs_a, ncs_b;
  logic [1:0] gid_a, gid_b;
  logic       busy_a, busy_b;

  int vec = 0;
  int errs = 0;

  // Model: owner index (-1 when free), remaining gap cycles, last owner.
  int m_owner[2], m_gap[2], m_last[2], m_hold[2];
  int turns[2] = '{1, 3};

  always #5 clk = ~clk;

  tri_state_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(1), .MAX_HOLD(MAXH)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .nCS(ncs_a), .grant_id(gid_a), .bus_busy(busy_a));

  tri_state_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(3), .MAX_HOLD(MAXH)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .nCS(ncs_b), .grant_id(gid_b), .bus_busy(busy_b));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ncs(input int o);
    logic [3:0] v;
    v = 4'hF;
    if (o >= 0) v[o] = 1'b0;
    return v;
  endfunction

  task automatic model_reset(input int d);
    m_owner[d] = -1; m_gap[d] = 0; m_last[d] = 3; m_hold[d] = 0;
  endtask

  task automatic model_edge(input int d, input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      model_reset(d);
      return;
    end
    if (m_owner[d] >= 0) begin
      m_hold[d]++;
      if (!r[m_owner[d]] || (TIMEOUT && m_hold[d] == MAXH)) begin
        m_owner[d] = -1;
        m_gap[d]   = turns[d];
      end
    end else begin
      if (m_gap[d] > 0) m_gap[d]--;
      if (m_gap[d] == 0) begin
        w = pick(r, m_last[d]);
        if (w >= 0) begin
          m_owner[d] = w; m_last[d] = w; m_hold[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_dut(input int d, input logic [3:0] n, input logic [1:0] g, input logic b);
    string s;
    s = (d == 0) ? "a" : "b";
    chk({"ncs_", s}, n, exp_ncs(m_owner[d]));
    chk({"busy_", s}, b, m_owner[d] >= 0);
    if (m_owner[d] >= 0) chk({"gid_", s}, g, m_owner[d]);
    chk({"onehot_", s}, $countones(~n) <= 1, 1);
    chk({"busy_cons_", s}, b, n != 4'hF);
  endtask

  task automatic check_all();
    chk_dut(0, ncs_a, gid_a, busy_a);
    chk_dut(1, ncs_b, gid_b, busy_b);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, req_a, rst_a);
    model_edge(1, req_b, rst_b);
    #1;
    check_all();
  endtask

  task automatic reset_a();
    rst_a = 1'b1; model_reset(0);
    #1; check_all();
    tick();
    rst_a = 1'b0;
  endtask

  int         hi, w;
  int         order[$];
  int         exp_order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] e;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = '0; req_b = '0;
    model_reset(0); model_reset(1);
    tick(); tick();
    chk("rst_ncs", ncs_a, 4'hF);
    chk("rst_busy", busy_a, 0);
    chk("rst_gid", gid_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Single requester takes the bus one cycle after sampling.
    req_a = 4'b0001;
    tick();
    chk("first_ncs", ncs_a, 4'b1110);
    chk("first_gid", gid_a, 0);
    chk("first_busy", busy_a, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
`ifndef TRI_STATE_ARB_TIMEOUT_EN
      chk("hold_ncs", ncs_a, 4'b1110);
`endif
    end
    req_a = '0; tick(); tick(); tick();

    // Round robin with every owner dropping req for one cycle.
    reset_a();
    req_a = 4'hF;
    hi = 0;
    for (int n = 0; n < 5; n++) begin
      w = 0;
      while (!busy_a && w < 10) begin
        tick();
        if (!busy_a) hi++;
        w++;
      end
      chk("rr_grant_seen", busy_a, 1);
      order.push_back(int'(gid_a));
      if (n > 0) chk("rr_turn_gap", hi, 1);
      req_a = 4'hF & ~(4'b0001 << gid_a);
      tick();
      hi = busy_a ? 0 : 1;
      req_a = 4'hF;
    end
    for (int n = 0; n < 5; n++) chk("rr_order", order[n], exp_order[n]);
    req_a = '0; tick(); tick();

    // Three-cycle turnaround: request changes inside TURN are not seen early.
    req_b = 4'b0100;
    tick();
    chk("b_own2", ncs_b, 4'b1011);
    tick();
    req_b = 4'b0000; tick();
    chk("b_turn0", ncs_b, 4'hF);
    req_b = 4'b1010; tick();
    chk("b_turn1", ncs_b, 4'hF);
    req_b = 4'b1000; tick();
    chk("b_turn2", ncs_b, 4'hF);
    tick();
    chk("b_own3", ncs_b, 4'b0111);
    req_b = '0; tick(); tick(); tick(); tick();

    // Asynchronous reset while owner 1 holds the bus.
    reset_a();
    req_a = 4'b0010;
    tick();
    chk("pre_rst_ncs", ncs_a, 4'b1101);
    #2;
    rst_a = 1'b1; model_reset(0);
    #1;
    chk("async_rst_ncs", ncs_a, 4'hF);
    chk("async_rst_busy", busy_a, 0);
    tick();
    rst_a = 1'b0; req_a = 4'b0110;
    tick();
    chk("post_rst_gid", gid_a, 1);
    req_a = '0; tick(); tick();

`ifdef TRI_STATE_ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD grant cycles.
    reset_a();
    req_a = 4'b0011;
    for (int c = 0; c < 27; c++) begin
      tick();
      if (c < 8) e = 4'b1110;
      else if (c == 8) e = 4'hF;
      else if (c < 17) e = 4'b1101;
      else if (c == 17) e = 4'hF;
      else e = 4'b1110;
      chk("timeout_seq", ncs_a, e);
    end
    req_a = '0; tick(); tick();
`endif

    // Random traffic on both instances.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) req_a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) req_b = 4'($urandom_range(0, 15));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
